// File: rtl/bev_dram_responder_pkg.sv
// Shared types and constants for the BEV box-inventory DRAM responder.
package BEV_DRAM_pkg;

  localparam logic [16:0] BASE_ADDR  = 17'h10000;
  localparam int          DEPTH      = 256;
  localparam int          REC_STRIDE = 8;
  localparam int          REC_SHIFT  = $clog2(REC_STRIDE);

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_R_ACC,
    ST_R_WAIT,
    ST_R_SEND,
    ST_AW_ACC,
    ST_W_ACC,
    ST_B_WAIT,
    ST_B_SEND
  } dram_state_t;

endpackage

// File: rtl/bev_dram_responder_if.sv
// AXI4-Lite channel bundle between the bridge (master) and the DRAM responder (slave).
interface bev_dram_if
  import BEV_DRAM_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 64
);

  logic              AR_VALID;
  logic [ADDR_W-1:0] AR_ADDR;
  logic              AR_READY;
  logic              R_VALID;
  logic [DATA_W-1:0] R_DATA;
  resp_t             R_RESP;
  logic              R_READY;
  logic              AW_VALID;
  logic [ADDR_W-1:0] AW_ADDR;
  logic              AW_READY;
  logic              W_VALID;
  logic [DATA_W-1:0] W_DATA;
  logic              W_READY;
  logic              B_VALID;
  resp_t             B_RESP;
  logic              B_READY;

  modport master (
    output AR_VALID, AR_ADDR, R_READY, AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
    input  AR_READY, R_VALID, R_DATA, R_RESP, AW_READY, W_READY, B_VALID, B_RESP
  );

  modport slave (
    input  AR_VALID, AR_ADDR, R_READY, AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
    output AR_READY, R_VALID, R_DATA, R_RESP, AW_READY, W_READY, B_VALID, B_RESP
  );

endinterface

// File: rtl/bev_dram_responder_array.sv
// Box-record storage: synchronous write, combinational read, contents survive reset.
module bev_dram_array #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 64,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/bev_dram_responder.sv
// AXI4-Lite slave serving BEV box records with programmable read/write latency.
// One transaction in flight at a time; writes take priority over reads in IDLE.
module bev_dram_responder #(
  parameter int              ADDR_W    = 17,
  parameter int              DATA_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = BEV_DRAM_pkg::BASE_ADDR,
  parameter int              DEPTH     = BEV_DRAM_pkg::DEPTH,
  parameter int              RD_LAT    = 2,
  parameter int              WR_LAT    = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  bev_dram_if.slave bus
);

  import BEV_DRAM_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 4;

  dram_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [ADDR_W-1:0] offs;
  logic [ADDR_W-1:0] idxFull;
  logic              addrOk;
  logic              we;
  resp_t             resp;
  logic [DATA_W-1:0] rdata;

  assign offs    = addr_q - BASE_ADDR;
  assign idxFull = offs >> REC_SHIFT;
  assign addrOk  = (addr_q >= BASE_ADDR) && (addr_q[REC_SHIFT-1:0] == '0) &&
                   (32'(idxFull) < 32'(DEPTH));
  assign resp    = addrOk ? RESP_OKAY : RESP_SLVERR;
  // Commit happens on the W handshake itself, so a later read always sees it.
  assign we      = (state_q == ST_W_ACC) && bus.W_VALID && addrOk;

  bev_dram_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .idx_i   (idxFull[IDX_W-1:0]),
    .we_i    (we),
    .wdata_i (bus.W_DATA),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // The accept cycle counts as the first latency cycle, so a latency of 1 skips the wait state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.AW_VALID) begin
          state_d = ST_AW_ACC;
        end else if (bus.AR_VALID) begin
          state_d = ST_R_ACC;
        end
      end
      ST_R_ACC: begin
        addr_d = bus.AR_ADDR;
        cnt_d  = CNT_W'(RD_LAT - 1);
        if (RD_LAT == 1) begin
          state_d = ST_R_SEND;
        end else begin
          state_d = ST_R_WAIT;
        end
      end
      ST_R_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_R_SEND;
        end
      end
      ST_R_SEND: begin
        if (bus.R_READY) begin
          state_d = ST_IDLE;
        end
      end
      ST_AW_ACC: begin
        addr_d  = bus.AW_ADDR;
        state_d = ST_W_ACC;
      end
      ST_W_ACC: begin
        if (bus.W_VALID) begin
          cnt_d = CNT_W'(WR_LAT - 1);
          if (WR_LAT == 1) begin
            state_d = ST_B_SEND;
          end else begin
            state_d = ST_B_WAIT;
          end
        end
      end
      ST_B_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_B_SEND;
        end
      end
      ST_B_SEND: begin
        if (bus.B_READY) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are pure state decodes, so reset zeroes them without waiting for a clock.
  always_comb begin
    bus.AR_READY = (state_q == ST_R_ACC);
    bus.AW_READY = (state_q == ST_AW_ACC);
    bus.W_READY  = (state_q == ST_W_ACC);
    bus.R_VALID  = (state_q == ST_R_SEND);
    bus.B_VALID  = (state_q == ST_B_SEND);
    bus.R_RESP   = RESP_OKAY;
    bus.B_RESP   = RESP_OKAY;
    bus.R_DATA   = '0;
    if (state_q == ST_R_SEND) begin
      bus.R_RESP = resp;
      if (addrOk) begin
        bus.R_DATA = rdata;
      end
    end
    if (state_q == ST_B_SEND) begin
      bus.B_RESP = resp;
    end
  end

endmodule

// File: tb/tb_bev_dram_responder.sv
// Table-driven scoreboard bench for bev_dram_responder at latencies 2, 1 and 15.
module tb_bev_dram_responder;

  import BEV_DRAM_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  int          sel;
  logic        arValid, rReady, awValid, wValid, bReady;
  logic [16:0] arAddr, awAddr;
  logic [63:0] wData;

  logic        arReady, rValid, awReady, wReady, bValid;
  logic [63:0] rData;
  logic [1:0]  rResp, bResp;
  logic        anyOut;

  logic [2:0]  outArReady, outRValid, outAwReady, outWReady, outBValid;
  logic [63:0] outRData [3];
  logic [1:0]  outRResp [3];
  logic [1:0]  outBResp [3];

  // Three responders share stimulus; only the selected one sees valid requests.
  for (genvar g = 0; g < 3; g++) begin : gDut
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    bev_dram_if #(.ADDR_W(17), .DATA_W(64)) busIf ();

    assign busIf.AR_VALID = arValid && (sel == g);
    assign busIf.AR_ADDR  = arAddr;
    assign busIf.R_READY  = rReady;
    assign busIf.AW_VALID = awValid && (sel == g);
    assign busIf.AW_ADDR  = awAddr;
    assign busIf.W_VALID  = wValid && (sel == g);
    assign busIf.W_DATA   = wData;
    assign busIf.B_READY  = bReady;

    assign outArReady[g] = busIf.AR_READY;
    assign outRValid[g]  = busIf.R_VALID;
    assign outAwReady[g] = busIf.AW_READY;
    assign outWReady[g]  = busIf.W_READY;
    assign outBValid[g]  = busIf.B_VALID;
    assign outRData[g]   = busIf.R_DATA;
    assign outRResp[g]   = busIf.R_RESP;
    assign outBResp[g]   = busIf.B_RESP;

    bev_dram_responder #(
      .ADDR_W    (17),
      .DATA_W    (64),
      .BASE_ADDR (17'h10000),
      .DEPTH     (256),
      .RD_LAT    (LAT),
      .WR_LAT    (LAT)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (busIf)
    );
  end

  assign arReady = outArReady[sel];
  assign rValid  = outRValid[sel];
  assign awReady = outAwReady[sel];
  assign wReady  = outWReady[sel];
  assign bValid  = outBValid[sel];
  assign rData   = outRData[sel];
  assign rResp   = outRResp[sel];
  assign bResp   = outBResp[sel];
  assign anyOut  = arReady | rValid | (|rData) | (|rResp) | awReady | wReady | bValid | (|bResp);

  typedef struct {
    int          sel;
    bit          isWrite;
    logic [16:0] addr;
    logic [63:0] data;
    int          hold;
    bit          early;
    logic [1:0]  expResp;
    logic [63:0] expData;
    int          expLat;
  } vec_t;

  typedef struct {
    logic [1:0]  resp;
    logic [63:0] data;
    int          lat;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] required);
    checks++;
    if (act !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, required);
    end
  endtask

  task automatic readTxn(input vec_t v);
    exp_t        e;
    logic [63:0] held;
    int          n;
    int          lat;
    @(negedge clk);
    arAddr  = v.addr;
    arValid = 1'b1;
    rReady  = v.early;
    n = 0;
    while (!arReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("arReady", 64'(arReady), 64'd1);
    @(negedge clk);
    arValid = 1'b0;
    lat = 1;
    while (!rValid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = sbQ.pop_front();
    checkOutput("rLatency", 64'(lat), 64'(e.lat));
    held = rData;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      checkOutput("rHoldValid", 64'(rValid), 64'd1);
      checkOutput("rHoldData", rData, held);
    end
    rReady = 1'b1;
    checkOutput("rData", rData, e.data);
    checkOutput("rResp", 64'(rResp), 64'(e.resp));
    @(negedge clk);
    rReady = 1'b0;
    checkOutput("rValidDrop", 64'(rValid), 64'd0);
    checkOutput("rDataIdle", rData, 64'd0);
  endtask

  task automatic writeTxn(input vec_t v);
    exp_t       e;
    logic [1:0] held;
    int         n;
    int         lat;
    @(negedge clk);
    awAddr  = v.addr;
    awValid = 1'b1;
    wData   = v.data;
    bReady  = v.early;
    n = 0;
    while (!awReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("awReady", 64'(awReady), 64'd1);
    @(negedge clk);
    awValid = 1'b0;
    wValid  = 1'b1;
    n = 0;
    while (!wReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wReady", 64'(wReady), 64'd1);
    @(negedge clk);
    wValid = 1'b0;
    lat = 1;
    while (!bValid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = sbQ.pop_front();
    checkOutput("bLatency", 64'(lat), 64'(e.lat));
    held = bResp;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      checkOutput("bHoldValid", 64'(bValid), 64'd1);
      checkOutput("bHoldResp", 64'(bResp), 64'(held));
    end
    bReady = 1'b1;
    checkOutput("bResp", 64'(bResp), 64'(e.resp));
    @(negedge clk);
    bReady = 1'b0;
    checkOutput("bValidDrop", 64'(bValid), 64'd0);
    checkOutput("bRespIdle", 64'(bResp), 64'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    sel    = v.sel;
    e.resp = v.expResp;
    e.data = v.expData;
    e.lat  = v.expLat;
    sbQ.push_back(e);
    if (v.isWrite) writeTxn(v);
    else           readTxn(v);
  endtask

  // Write and read to idx 255 requested together; the write must be served first.
  task automatic simultaneous();
    int          awCyc = -1;
    int          arCyc = -1;
    bit          done  = 1'b0;
    bit          dropAw, dropAr, dropW, rHs;
    logic [63:0] gotData = 64'd0;
    logic [1:0]  gotResp = 2'b11;
    logic [1:0]  gotB    = 2'b11;
    exp_t        e;
    sel    = 0;
    e.resp = 2'b00;
    e.data = 64'h1;
    e.lat  = 0;
    sbQ.push_back(e);
    @(negedge clk);
    awAddr = 17'h107F8; arAddr = 17'h107F8; wData = 64'h1;
    awValid = 1'b1; arValid = 1'b1; wValid = 1'b1; bReady = 1'b1; rReady = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (awReady && awCyc < 0) awCyc = c;
      if (arReady && arCyc < 0) arCyc = c;
      if (bValid) gotB = bResp;
      dropAw = awReady;
      dropAr = arReady;
      dropW  = wReady && wValid;
      rHs    = rValid && rReady;
      if (rHs) begin
        gotData = rData;
        gotResp = rResp;
      end
      @(posedge clk);
      #1;
      if (dropAw) awValid = 1'b0;
      if (dropAr) arValid = 1'b0;
      if (dropW)  wValid  = 1'b0;
      if (rHs)    done    = 1'b1;
    end
    e = sbQ.pop_front();
    checkOutput("simAwFirst", 64'(awCyc >= 0 && arCyc > awCyc), 64'd1);
    checkOutput("simBResp", 64'(gotB), 64'd0);
    checkOutput("simRData", gotData, e.data);
    checkOutput("simRResp", 64'(gotResp), 64'(e.resp));
    rReady = 1'b0;
    bReady = 1'b0;
    arValid = 1'b0;
    awValid = 1'b0;
    wValid = 1'b0;
    @(negedge clk);
    checkOutput("simIdle", 64'(anyOut), 64'd0);
  endtask

  task automatic resetInReadWait();
    int n;
    sel = 0;
    @(negedge clk);
    arAddr  = 17'h10028;
    arValid = 1'b1;
    n = 0;
    while (!arReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    arValid = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkOutput("rstRWaitOut", 64'(anyOut), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rstRWaitAbort", 64'(rValid), 64'd0);
    end
  endtask

  task automatic resetInWriteAccept();
    int n;
    sel = 0;
    @(negedge clk);
    awAddr  = 17'h10028;
    awValid = 1'b1;
    wData   = 64'h0BAD;
    n = 0;
    while (!awReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    awValid = 1'b0;
    checkOutput("wAccReady", 64'(wReady), 64'd1);
    #2 rst_n = 1'b0;
    #1 checkOutput("rstWAccOut", 64'(anyOut), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wValid = 1'b1;
    @(negedge clk);
    wValid = 1'b0;
    checkOutput("rstWAccIdle", 64'(wReady | bValid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rstWAccNoResp", 64'(bValid), 64'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    rst_n = 1'b1;
    sel = 0;
    arValid = 1'b0; rReady = 1'b0; awValid = 1'b0; wValid = 1'b0; bReady = 1'b0;
    arAddr = '0; awAddr = '0; wData = '0;

    //          sel wr addr        data                    hold early resp   expData                 lat
    vecs[0]  = '{0, 1, 17'h10000, 64'h1111_2222_3333_4444, 0, 0, 2'b00, 64'h0,                  2};
    vecs[1]  = '{0, 1, 17'h10008, 64'hDEAD_BEEF_0123_4567, 0, 0, 2'b00, 64'h0,                  2};
    vecs[2]  = '{0, 0, 17'h10008, 64'h0,                   0, 0, 2'b00, 64'hDEAD_BEEF_0123_4567, 2};
    vecs[3]  = '{0, 1, 17'h10018, 64'hA5A5_0000_FFFF_1234, 3, 0, 2'b00, 64'h0,                  2};
    vecs[4]  = '{0, 0, 17'h10018, 64'h0,                   5, 0, 2'b00, 64'hA5A5_0000_FFFF_1234, 2};
    vecs[5]  = '{0, 0, 17'h0FFF8, 64'h0,                   0, 0, 2'b10, 64'h0,                  2};
    vecs[6]  = '{0, 1, 17'h10004, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 2'b10, 64'h0,                  2};
    vecs[7]  = '{0, 0, 17'h10000, 64'h0,                   0, 1, 2'b00, 64'h1111_2222_3333_4444, 2};
    vecs[8]  = '{0, 1, 17'h10800, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 2'b10, 64'h0,                  2};
    vecs[9]  = '{0, 0, 17'h10800, 64'h0,                   0, 0, 2'b10, 64'h0,                  2};
    vecs[10] = '{0, 1, 17'h10028, 64'h55,                  0, 0, 2'b00, 64'h0,                  2};
    vecs[11] = '{1, 1, 17'h10010, 64'h5,                   0, 0, 2'b00, 64'h0,                  1};
    vecs[12] = '{1, 0, 17'h10010, 64'h0,                   0, 1, 2'b00, 64'h5,                  1};
    vecs[13] = '{2, 1, 17'h10020, 64'h7,                   2, 0, 2'b00, 64'h0,                  15};
    vecs[14] = '{2, 0, 17'h10020, 64'h0,                   1, 0, 2'b00, 64'h7,                  15};

    #1 rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1 checkOutput("resetOut", 64'(anyOut), 64'd0);
    end
    sel = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
    end

    simultaneous();
    resetInReadWait();
    resetInWriteAccept();

    v = '{0, 0, 17'h10028, 64'h0, 0, 0, 2'b00, 64'h55, 2};
    applyStimulus(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bev_dram_responder.md
Name: bev_dram_responder

Overview:
- Synthesizable AXI4-Lite slave that serves the box-inventory storage which the bridge reads and writes on behalf of BEV.
- Replaces the behavioural DRAM model with cycle-accurate RTL, so the bridge/BEV pair can be exercised against a real responder.
- Holds DEPTH x 64-bit box records, one per box index.
- Returns read data and write acknowledgements after programmable latencies.

Parameters:
- ADDR_W, 17, AXI address width.
- DATA_W, 64, AXI data width; equals one box record.
- BASE_ADDR, 17'h10000, byte address of box index 0.
- DEPTH, 256, number of box records.
- RD_LAT, 2, cycles from AR handshake to R_VALID rise; legal range 1..15.
- WR_LAT, 2, cycles from W handshake to B_VALID rise; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- AR_VALID  in  1  read address valid.
- AR_ADDR  in  ADDR_W  read byte address.
- AR_READY  out  1  read address accepted.
- R_VALID  out  1  read data valid.
- R_DATA  out  DATA_W  read data.
- R_RESP  out  2  read response.
- R_READY  in  1  master accepts read data.
- AW_VALID  in  1  write address valid.
- AW_ADDR  in  ADDR_W  write byte address.
- AW_READY  out  1  write address accepted.
- W_VALID  in  1  write data valid.
- W_DATA  in  DATA_W  write data.
- W_READY  out  1  write data accepted.
- B_VALID  out  1  write response valid.
- B_RESP  out  2  write response.
- B_READY  in  1  master accepts write response.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs are 0, the FSM goes to IDLE and the latency counter is cleared.
  - Storage contents are not reset; they persist across reset.
  - Reset during any state aborts the transaction immediately. No partial write is committed unless the W handshake has already occurred.
- Only one transaction is in flight at a time; there is a single shared FSM.
- States and transitions:
  - IDLE:
    - AW_VALID goes to AW_ACC.
    - Otherwise AR_VALID goes to R_ACC.
    - Write wins when AW_VALID and AR_VALID are high in the same cycle; the read waits.
  - R_ACC: AR_READY=1 for exactly one cycle. Latch AR_ADDR, load counter=RD_LAT-1, go to R_WAIT.
  - R_WAIT:
    - Counter decrements each cycle.
    - At 0: drive R_DATA/R_RESP, set R_VALID=1, go to R_SEND.
    - R_VALID therefore rises exactly RD_LAT cycles after the AR handshake cycle.
  - R_SEND:
    - Hold R_VALID, R_DATA and R_RESP stable until R_READY is high.
    - On the handshake cycle, drop R_VALID on the next edge and return to IDLE.
  - AW_ACC: AW_READY=1 for one cycle, latch AW_ADDR, go to W_ACC.
  - W_ACC:
    - W_READY=1 and held until W_VALID is high.
    - On the handshake, commit W_DATA if the address is valid, load counter=WR_LAT-1, go to B_WAIT.
  - B_WAIT: counter reaches 0, then B_VALID=1, go to B_SEND.
  - B_SEND: hold B_VALID/B_RESP until B_READY; on the handshake, return to IDLE.
- Address decode:
  - idx = (addr - BASE_ADDR) >> 3.
  - The address is valid only if addr >= BASE_ADDR, addr[2:0]==0 and idx < DEPTH.
- Response codes:
  - OKAY=2'b00 for a valid address.
  - SLVERR=2'b10 for an invalid address. On SLVERR, R_DATA=0 and no write is committed.
- Read-after-write: a read that follows a write to the same index returns the new data, because the write commits before B_VALID.
- R_DATA is 0 whenever R_VALID is 0; R_RESP and B_RESP are 0 when their valid is low.
- The master may hold R_READY/B_READY high early; the handshake then completes in the first valid cycle.

Decomposition:
- Shared package BEV_DRAM_pkg holds:
  - typedef resp_t for OKAY/SLVERR;
  - typedef enum dram_state_t;
  - constants BASE_ADDR, DEPTH and the record byte stride 8.
- One sub-module, bev_dram_array: DEPTH x DATA_W synchronous-write, combinational-read storage with an idx/we/wdata/rdata interface. The FSM lives in the top module.

Test Plan:
1. Write then read:
   - Stimulus: AW_ADDR=17'h10008 with W_DATA=64'hDEAD_BEEF_0123_4567, then AR_ADDR=17'h10008.
   - Response: B_RESP=00; R_DATA=64'hDEAD_BEEF_0123_4567, R_RESP=00.
   - Timing: R_VALID rises 2 cycles after AR_READY.
2. Backpressure:
   - Stimulus: read idx 3 with R_READY held low for 5 cycles.
   - Response: R_VALID and R_DATA stay constant for all 5 cycles; R_VALID drops one cycle after R_READY rises.
3. Invalid address:
   - Stimulus: AR_ADDR=17'h0FFF8, then AW_ADDR=17'h10004 with W_DATA=all-ones.
   - Response: R_RESP=10 with R_DATA=0; B_RESP=10; a following read of idx 0 returns the original content.
4. Simultaneous request and boundary index:
   - Stimulus: AW_VALID and AR_VALID asserted on the same edge, both to idx 255 (17'h107F8), write data 64'h1.
   - Response: AW_READY precedes AR_READY; the read returns 64'h1.
5. Reset mid-transaction:
   - Stimulus: drop rst_n during R_WAIT and during W_ACC (before W_VALID).
   - Response: all outputs are 0 asynchronously; the FSM is in IDLE after release; the target record is unchanged.
6. Latency sweep:
   - Stimulus: RD_LAT=WR_LAT=1 and RD_LAT=WR_LAT=15.
   - Response: the AR-to-R_VALID and W-to-B_VALID distances equal the parameter in cycles.
